// File: rtl/qracc_pkg.sv
// Shared types and constants for the QRAcc datapath blocks.
// Holds the output packer's state encoding and counter width.
package qracc_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PACK,
    OP_DONE
  } out_packer_state_t;

  localparam int OUT_PACKER_CNT_BITS = 16;

endpackage

// File: rtl/qracc_output_packer.sv
// Collects quantized output vectors into full activation-buffer words and
// writes them at an auto-incrementing byte address; flush pads a partial word.
module qracc_output_packer
  import qracc_pkg::*;
#(
  parameter int numElements    = 32,
  parameter int elementBits    = 4,
  parameter int interfaceWidth = 512,
  parameter int addrWidth      = 32,
  parameter int dataSize       = 8
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start_i,
  input  logic [addrWidth-1:0]           base_addr_i,
  input  logic                           flush_i,
  input  logic [numElements*elementBits-1:0] data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic                           wr_en_o,
  output logic [addrWidth-1:0]           wr_addr_o,
  output logic [interfaceWidth-1:0]      wr_data_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic [OUT_PACKER_CNT_BITS-1:0] words_written_o
);

  localparam int vecWidth  = numElements * elementBits;
  localparam int numSlots  = interfaceWidth / vecWidth;
  localparam int addrStep  = interfaceWidth / dataSize;
  localparam int SLOT_BITS = (numSlots > 1) ? $clog2(numSlots) : 1;

  if (interfaceWidth % vecWidth != 0) begin : g_width_check
    $error("interfaceWidth must be a multiple of numElements*elementBits");
  end

  out_packer_state_t         state, state_next;
  logic [SLOT_BITS-1:0]      slot_idx, slot_next;
  logic [interfaceWidth-1:0] pack_reg, pack_next, word;
  logic [addrWidth-1:0]      addr, addr_next;
  logic                      accept, last_slot, write;

  // Valid/ready: a vector transfers on any cycle where valid_i && ready_o;
  // ready_o is high exactly while in PACK. Writes never back-pressure.
  always_comb begin
    state_next = state;
    slot_next  = slot_idx;
    pack_next  = pack_reg;
    word       = pack_reg;
    addr_next  = addr;
    write      = 1'b0;
    accept     = 1'b0;
    last_slot  = (slot_idx == SLOT_BITS'(numSlots - 1));
    case (state)
      OP_IDLE: begin
        if (start_i) begin
          state_next = OP_PACK;
          slot_next  = '0;
          pack_next  = '0;
          addr_next  = base_addr_i;
        end
      end
      OP_PACK: begin
        accept = valid_i && ready_o;
        if (accept) begin
          word[slot_idx*vecWidth +: vecWidth] = data_i;
          if (last_slot) begin
            write     = 1'b1;
            slot_next = '0;
            pack_next = '0;
          end else begin
            slot_next = slot_idx + SLOT_BITS'(1);
            pack_next = word;
          end
        end
        if (flush_i) begin
          state_next = OP_DONE;
          // Unfilled upper slots are already zero because the pack register
          // clears after every completed word.
          if (!write && (accept || slot_idx != '0)) write = 1'b1;
          slot_next = '0;
          pack_next = '0;
        end
        if (write) addr_next = addr + addrWidth'(addrStep);
      end
      OP_DONE: state_next = OP_IDLE;
      default: state_next = OP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state           <= OP_IDLE;
      slot_idx        <= '0;
      pack_reg        <= '0;
      addr            <= '0;
      ready_o         <= 1'b0;
      wr_en_o         <= 1'b0;
      wr_addr_o       <= '0;
      wr_data_o       <= '0;
      done_o          <= 1'b0;
      busy_o          <= 1'b0;
      words_written_o <= '0;
    end else begin
      state    <= state_next;
      slot_idx <= slot_next;
      pack_reg <= pack_next;
      addr     <= addr_next;
      ready_o  <= (state_next == OP_PACK);
      busy_o   <= (state_next != OP_IDLE);
      done_o   <= (state_next == OP_DONE);
      wr_en_o  <= write;
      if (write) begin
        wr_addr_o <= addr;
        wr_data_o <= word;
      end
      if (state == OP_IDLE && start_i) begin
        words_written_o <= '0;
      end else if (write && words_written_o != '1) begin
        words_written_o <= words_written_o + OUT_PACKER_CNT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_qracc_output_packer.sv
// Self-checking bench for qracc_output_packer: a queue-based layer model
// predicts every buffer write; scenario tasks check control outputs inline.
module tb_qracc_output_packer;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start_i = 1'b0;
  logic [31:0]  base_addr_i = '0;
  logic         flush_i = 1'b0;
  logic [127:0] data_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic         wr_en_o;
  logic [31:0]  wr_addr_o;
  logic [511:0] wr_data_o;
  logic         done_o;
  logic         busy_o;
  logic [15:0]  words_written_o;

  int errors = 0;
  int checks = 0;
  int neg_cnt = 0;

  // Behavioural model: vectors of the current layer, plus expected writes.
  logic [127:0] vec_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [511:0] exp_q[$];
  int           exp_due_q[$];
  logic [31:0]  m_addr;
  logic [15:0]  m_words;
  bit           armed;
  bit           done_phase;

  qracc_output_packer dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .base_addr_i(base_addr_i),
    .flush_i(flush_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .done_o(done_o), .busy_o(busy_o), .words_written_o(words_written_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic [511:0] pack_vecs();
    logic [511:0] w = '0;
    for (int i = 0; i < vec_q.size(); i++) w = w | ({384'b0, vec_q[i]} << (i * 128));
    return w;
  endfunction

  function automatic void push_exp();
    exp_addr_q.push_back(m_addr);
    exp_q.push_back(pack_vecs());
    exp_due_q.push_back(neg_cnt + 1);
    m_addr = m_addr + 32'd64;
    if (m_words != 16'hFFFF) m_words = m_words + 16'd1;
    vec_q.delete();
  endfunction

  function automatic void model_clear();
    armed = 0; done_phase = 0; m_addr = '0; m_words = '0;
    vec_q.delete(); exp_addr_q.delete(); exp_q.delete(); exp_due_q.delete();
  endfunction

  // Scoreboard: every write must match the oldest expected word, on time.
  always @(negedge clk) begin
    neg_cnt++;
    if (nrst && wr_en_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected addr=%h", wr_addr_o);
      end else begin
        logic [31:0]  a;
        logic [511:0] d;
        int           due;
        a = exp_addr_q.pop_front(); d = exp_q.pop_front(); due = exp_due_q.pop_front();
        if (wr_addr_o !== a || wr_data_o !== d || neg_cnt != due) begin
          errors++;
          $display("FAIL wr_word addr=%h exp=%h cyc=%0d exp=%0d data=%h exp=%h",
                   wr_addr_o, a, neg_cnt, due, wr_data_o, d);
        end
      end
    end
    while (exp_due_q.size() > 0 && exp_due_q[0] < neg_cnt) begin
      checks++; errors++;
      $display("FAIL wr_missing addr=%h", exp_addr_q[0]);
      void'(exp_addr_q.pop_front()); void'(exp_q.pop_front()); void'(exp_due_q.pop_front());
    end
  end

  // One clock of stimulus; the model follows the layer rules at the edge.
  task automatic drive(input logic v, input logic [127:0] d, input logic s,
                       input logic [31:0] b, input logic f);
    valid_i = v; data_i = d; start_i = s; base_addr_i = b; flush_i = f;
    @(posedge clk);
    if (nrst) begin
      if (done_phase) begin
        done_phase = 0;
      end else if (armed) begin
        if (v) begin
          vec_q.push_back(d);
          if (vec_q.size() == 4) push_exp();
        end
        if (f) begin
          if (vec_q.size() > 0) push_exp();
          armed = 0; done_phase = 1;
        end
      end else if (s) begin
        armed = 1; m_addr = b; m_words = '0; vec_q.delete();
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic apply_reset();
    nrst = 1'b0; valid_i = 0; start_i = 0; flush_i = 0; data_i = '0; base_addr_i = '0;
    model_clear();
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready_o); end
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en_o); end
    checks++; if (wr_addr_o !== 32'h0) begin errors++; $display("FAIL rst_wr_addr got=%h exp=0", wr_addr_o); end
    checks++; if (wr_data_o !== 512'h0) begin errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (words_written_o !== 16'h0) begin errors++; $display("FAIL rst_words got=%h exp=0", words_written_o); end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", ready_o); end
    end
    idle();
  endtask

  task automatic test_single_word();
    drive(1'b0, '0, 1'b1, 32'h1000, 1'b0);
    checks++; if (ready_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL start_ready got=%b/%b exp=1/1", ready_o, busy_o); end
    drive(1'b1, {32{4'h1}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h2}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h3}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h4}}, 1'b0, '0, 1'b0);
    checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 32'h1000) begin
      errors++; $display("FAIL word_write en=%b addr=%h exp 1/1000", wr_en_o, wr_addr_o); end
    checks++; if (wr_data_o !== {{32{4'h4}}, {32{4'h3}}, {32{4'h2}}, {32{4'h1}}}) begin
      errors++; $display("FAIL word_data got=%h", wr_data_o); end
    checks++; if (words_written_o !== 16'd1) begin
      errors++; $display("FAIL word_count got=%0d exp=1", words_written_o); end
    idle();
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL word_deassert got=%b exp=0", wr_en_o); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (done_o !== 1'b1 || ready_o !== 1'b0 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL empty_flush done=%b ready=%b wr=%b exp 1/0/0", done_o, ready_o, wr_en_o); end
    idle();
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++; $display("FAIL back_idle busy=%b done=%b exp 0/0", busy_o, done_o); end
  endtask

  task automatic test_partial_flush();
    drive(1'b0, '0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (done_o !== 1'b1 || wr_en_o !== 1'b1 || wr_addr_o !== 32'h80) begin
      errors++; $display("FAIL partial_flush done=%b wr=%b addr=%h exp 1/1/80", done_o, wr_en_o, wr_addr_o); end
    checks++; if (wr_data_o[511:256] !== 256'h0) begin
      errors++; $display("FAIL partial_pad got=%h exp=0", wr_data_o[511:256]); end
    checks++; if (words_written_o !== 16'd3) begin
      errors++; $display("FAIL partial_count got=%0d exp=3", words_written_o); end
    idle();
  endtask

  task automatic test_flush_after_full();
    drive(1'b0, '0, 1'b1, 32'h4000, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (done_o !== 1'b1 || wr_en_o !== 1'b0 || words_written_o !== 16'd2) begin
      errors++; $display("FAIL full_flush done=%b wr=%b words=%0d exp 1/0/2", done_o, wr_en_o, words_written_o); end
    idle();
  endtask

  task automatic test_flush_with_last();
    drive(1'b0, '0, 1'b1, 32'h2000, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    drive(1'b1, rand_vec(), 1'b0, '0, 1'b1);
    checks++; if (done_o !== 1'b1 || wr_en_o !== 1'b1 || wr_addr_o !== 32'h2000 || words_written_o !== 16'd1) begin
      errors++; $display("FAIL last_flush done=%b wr=%b addr=%h words=%0d", done_o, wr_en_o, wr_addr_o, words_written_o); end
    idle();
    checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL last_flush_extra got=%b exp=0", wr_en_o); end
  endtask

  task automatic test_wrap();
    drive(1'b0, '0, 1'b1, 32'hFFFF_FFC0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_addr wr=%b addr=%h exp 1/0", wr_en_o, wr_addr_o); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, '0, 1'b1, 32'h300, 1'b0);
    drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    drive(1'b1, rand_vec(), 1'b0, '0, 1'b0);
    nrst = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0 || busy_o !== 1'b0 || wr_en_o !== 1'b0) begin
      errors++; $display("FAIL midrst_out ready=%b busy=%b wr=%b exp 0/0/0", ready_o, busy_o, wr_en_o); end
    model_clear();
    @(negedge clk);
    #1 nrst = 1'b1;
    drive(1'b0, '0, 1'b1, 32'h200, 1'b0);
    drive(1'b1, {32{4'h5}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h6}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h7}}, 1'b0, '0, 1'b0);
    drive(1'b1, {32{4'h8}}, 1'b0, '0, 1'b0);
    checks++; if (wr_en_o !== 1'b1 || wr_addr_o !== 32'h200 ||
                  wr_data_o !== {{32{4'h8}}, {32{4'h7}}, {32{4'h6}}, {32{4'h5}}}) begin
      errors++; $display("FAIL midrst_word wr=%b addr=%h data=%h", wr_en_o, wr_addr_o, wr_data_o); end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle();
  endtask

  task automatic test_random();
    for (int layer = 0; layer < 8; layer++) begin
      int n;
      int sent;
      n = $urandom_range(0, 13);
      sent = 0;
      drive(1'b0, '0, 1'b1, $urandom, 1'b0);
      while (sent < n) begin
        logic v;
        v = ($urandom_range(0, 9) < 7);
        // Stray starts while packing must be ignored.
        drive(v, rand_vec(), ($urandom_range(0, 7) == 0), $urandom, 1'b0);
        if (v) sent++;
      end
      drive($urandom_range(0, 1), rand_vec(), 1'b0, '0, 1'b1);
      checks++; if (done_o !== 1'b1 || words_written_o !== m_words) begin
        errors++; $display("FAIL rand_done done=%b words=%0d exp=%0d", done_o, words_written_o, m_words); end
      idle();
      checks++; if (exp_q.size() != 0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL rand_drain pending=%0d busy=%b", exp_q.size(), busy_o); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_single_word();
    test_partial_flush();
    test_flush_after_full();
    test_flush_with_last();
    test_wrap();
    test_reset_mid();
    test_random();
    repeat (2) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qracc_output_packer.md
# qracc_output_packer

Write-back stage between `output_scaler_set` and the activation buffer's internal write port. It collects successive quantized output vectors (32 × 4 bit = 128 bit) into full-width internal buffer words (512 bit). It issues one buffer write per completed word at an auto-incrementing byte address. On flush it writes out any partially filled word, zero-padded, so a layer's output map lands contiguously in the activation buffer.

## Interface
- `numElements`, 32, output elements per vector
- `elementBits`, 4, bits per output element
- `interfaceWidth`, 512, internal buffer word width in bits; must be a multiple of `numElements*elementBits` (elaboration `$error` otherwise)
- `addrWidth`, 32, buffer byte-address width
- `dataSize`, 8, bits per buffer address unit (byte addressability)
- Derived: `vecWidth = numElements*elementBits`, `numSlots = interfaceWidth/vecWidth` (4), `addrStep = interfaceWidth/dataSize` (64)

Ports:
- `clk`  in  1  clock, rising edge
- `nrst`  in  1  asynchronous active-low reset
- `start_i`  in  1  pulse, arms packer; sampled only in IDLE
- `base_addr_i`  in  addrWidth  first write address, captured on `start_i`
- `flush_i`  in  1  pulse, end of layer; sampled only in PACK
- `data_i`  in  vecWidth  scaled output vector, element 0 at LSBs
- `valid_i`  in  1  `data_i` valid
- `ready_o`  out  1  packer accepts `data_i` this cycle
- `wr_en_o`  out  1  buffer write strobe, one cycle per word
- `wr_addr_o`  out  addrWidth  buffer byte address
- `wr_data_o`  out  interfaceWidth  packed word
- `done_o`  out  1  one-cycle pulse, layer write-back complete
- `busy_o`  out  1  state != IDLE
- `words_written_o`  out  16  words written since last `start_i`; saturates at 0xFFFF

## Operation
- States: IDLE, PACK, DONE.
- IDLE:
  - `ready_o=0`; `valid_i` ignored.
  - `start_i` captures `base_addr_i` into the address counter, clears the slot index and `words_written_o`, and goes to PACK.
- PACK:
  - `ready_o=1`.
  - Handshake: transfer when `valid_i && ready_o`. The vector is stored in slot `slot_idx`, at bits `[slot_idx*vecWidth +: vecWidth]`, and `slot_idx` increments.
  - On filling slot `numSlots-1`, the whole word is registered to the output, `slot_idx` returns to 0, and the pack register clears to zero.
  - Accepting a vector in the same cycle a completed word is being written is allowed; there is no bubble.
  - `start_i` in PACK is ignored.
- Flush:
  - `flush_i` in PACK moves to DONE.
  - A vector accepted in the same cycle is included before the flush takes effect.
  - If slots are filled (k>0 after that vector), the partial word is written with the unfilled upper slots set to 0.
  - If k=0 (including when that vector just completed a word), no padded write is issued.
- DONE:
  - Lasts one cycle: `ready_o=0` and `done_o=1`, then returns to IDLE.
- Address:
  - After every write the address increments by `addrStep`.
  - It wraps modulo 2^addrWidth with no error.
- Reset mid-operation: all state is lost, any partial word is discarded, and no write is issued.

## Timing
- Reset values: `ready_o=0`, `wr_en_o=0`, `wr_addr_o=0`, `wr_data_o=0`, `done_o=0`, `busy_o=0`, `words_written_o=0`. The state is IDLE, `slot_idx=0`, and the pack register is 0.
- `start_i` at edge N: `ready_o=1` and `busy_o=1` from N+1.
- Final vector of a word accepted at edge N: `wr_en_o=1` with data and address during N+1; `wr_en_o` deasserts at N+2 unless another word completes.
- `flush_i` at edge N: in cycle N+1, `done_o=1` and `ready_o=0`, and `wr_en_o=1` if a partial word exists. Back to IDLE at N+2.
- All outputs are registered. There is no combinational path from any input to any output.
- `wr_en_o` is never asserted for two different words in the same cycle. The buffer port always accepts, so there is no write back-pressure.

## Structure
- Add to `qracc_pkg`:
  - `typedef enum logic [1:0] {OP_IDLE, OP_PACK, OP_DONE} out_packer_state_t`
  - localparam `OUT_PACKER_CNT_BITS = 16`
- Instantiate between `output_scaler_set` (`y_o` → `data_i`) and the `ram_2w2r` internal write port. Driven by `qracc_controller` (`start_i`, `flush_i`, `valid_i`).
- Single module; no sub-module is warranted. Slot insertion uses an indexed part-select into the pack register.

## Test plan
- Start with base 0x1000, then 4 vectors 0x1…1, 0x2…2, 0x3…3, 0x4…4 back-to-back → one write to 0x1000 with data {0x4…4, 0x3…3, 0x2…2, 0x1…1}, one cycle after the fourth vector; `words_written_o=1`.
- Start with base 0x0, then 10 vectors, then flush → writes at 0x0 and 0x40 (full words) and at 0x80 holding vectors 9 and 10 in slots 0-1, upper 256 bits zero. `done_o` coincides with the 0x80 write; `words_written_o=3`.
- Flush right after a full word (8 vectors) → no padded write; `done_o=1` the cycle after flush; `words_written_o=2`.
- `valid_i` and `flush_i` in the same cycle as the 4th vector → the full word is written once, `done_o` in the same cycle, and no extra write.
- Base 0xFFFFFFC0, then 8 vectors → writes at 0xFFFFFFC0 then 0x00000000 (wrap).
- `nrst` asserted after 2 vectors, then a new start at 0x200 and 4 vectors → only one write, at 0x200, containing only the new vectors. `valid_i` in IDLE is never accepted (`ready_o=0`).
